// File: rtl/text_console_if.sv
// Byte-stream and renderer-read bundle for text_console.
// The console is the slave; the producer/renderer side is the master.
interface text_console_if #(
  parameter int COL_W = 6,
  parameter int ROW_W = 5
);
  logic [7:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [COL_W-1:0] rd_col;
  logic [ROW_W-1:0] rd_row;
  logic [7:0]       rd_char;
  logic [COL_W-1:0] cursor_col;
  logic [ROW_W-1:0] cursor_row;
  logic             busy;

  modport slave (
    input  in_data, in_valid, rd_col, rd_row,
    output in_ready, rd_char, cursor_col, cursor_row, busy
  );

  modport master (
    output in_data, in_valid, rd_col, rd_row,
    input  in_ready, rd_char, cursor_col, cursor_row, busy
  );
endinterface

// File: rtl/text_console.sv
// Character-cell text buffer: ASCII stream in, cursor-addressed writes into a
// COLS x ROWS character RAM, registered read port for the pixel pipeline.
module text_console #(
  parameter int          COLS  = 40,
  parameter int          ROWS  = 30,
  parameter int          COL_W = 6,
  parameter int          ROW_W = 5,
  parameter logic [7:0]  FILL  = 8'h20
) (
  input  logic          clk,
  input  logic          rst,
  text_console_if.slave bus
);
  localparam int NCELL = COLS * ROWS;
  localparam int AW    = $clog2(NCELL);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_clr_addr, w_clr_nxt;
  logic [COL_W-1:0] r_col, w_col_nxt;
  logic [ROW_W-1:0] r_row, w_row_nxt;
  logic             w_we;
  logic [AW-1:0]    w_waddr, w_cur_addr, w_raddr;
  logic [7:0]       w_wdata;
  logic             w_acc, w_rd_ok;
  logic [COL_W:0]   w_tab;
  logic [ROW_W-1:0] w_row_inc;
  logic [7:0]       r_mem [0:NCELL-1];
  logic [7:0]       r_rd_char;

  assign w_row_inc  = (r_row == ROW_W'(ROWS-1)) ? '0 : r_row + ROW_W'(1);
  // Next multiple of 8; one extra bit so a tab past the last column is visible.
  assign w_tab      = {1'b0, r_col | COL_W'(7)} + (COL_W+1)'(1);
  assign w_cur_addr = AW'(int'(r_row) * COLS + int'(r_col));

  // rst gates the handshake so no byte is taken during a reset cycle.
  assign bus.in_ready   = (r_state == S_IDLE) && !rst;
  assign bus.busy       = (r_state == S_CLEAR) || rst;
  assign bus.cursor_col = r_col;
  assign bus.cursor_row = r_row;
  assign bus.rd_char    = r_rd_char;
  assign w_acc          = bus.in_valid && bus.in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_clr_nxt   = r_clr_addr;
    w_col_nxt   = r_col;
    w_row_nxt   = r_row;
    w_we        = 1'b0;
    w_waddr     = w_cur_addr;
    w_wdata     = bus.in_data;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = r_clr_addr;
        w_wdata = FILL;
        if (r_clr_addr == AW'(NCELL-1)) begin
          w_state_nxt = S_IDLE;
          w_clr_nxt   = '0;
        end else begin
          w_clr_nxt   = r_clr_addr + AW'(1);
        end
      end
      S_IDLE: begin
        if (w_acc) begin
          if (bus.in_data >= 8'h20 && bus.in_data <= 8'h7E) begin
            w_we = 1'b1;
            if (r_col == COL_W'(COLS-1)) begin
              w_col_nxt = '0;
              w_row_nxt = w_row_inc;
            end else begin
              w_col_nxt = r_col + COL_W'(1);
            end
          end else begin
            case (bus.in_data)
              8'h0A: begin w_col_nxt = '0; w_row_nxt = w_row_inc; end
              8'h0D: w_col_nxt = '0;
              8'h08: if (r_col != '0) w_col_nxt = r_col - COL_W'(1);
              8'h09: begin
                if (w_tab >= (COL_W+1)'(COLS)) begin
                  w_col_nxt = '0;
                  w_row_nxt = w_row_inc;
                end else begin
                  w_col_nxt = w_tab[COL_W-1:0];
                end
              end
              8'h0C: begin
                w_state_nxt = S_CLEAR;
                w_clr_nxt   = '0;
                w_col_nxt   = '0;
                w_row_nxt   = '0;
              end
              default: ;
            endcase
          end
        end
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_col      <= '0;
      r_row      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_nxt;
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Out-of-range coordinates return FILL rather than aliasing another cell.
  assign w_rd_ok = (int'(bus.rd_col) < COLS) && (int'(bus.rd_row) < ROWS);
  assign w_raddr = AW'(int'(bus.rd_row) * COLS + int'(bus.rd_col));

  always_ff @(posedge clk) begin
    if (rst)          r_rd_char <= 8'h00;
    else if (w_rd_ok) r_rd_char <= r_mem[w_raddr];
    else              r_rd_char <= FILL;
  end
endmodule
